mem_arbiter: RTL and testbench

Shares the single external memory port between NUM_REQ memory_accessor instances. Requesters use the same addr/data/ready and receive/ready handshake that memory_accessor drives toward memory. Selection is round-robin. Exactly one transaction is in flight at a time, and each response returns only to the requester that issued it. Sits between the memory_accessor array and the memory interface.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory port bundle for mem_arbiter
// slave is the arbiter's view; master is the view of the requesters and memory driving it.
interface mem_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_ADDR_VALID;
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]            REQ_DATA_VALID;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic [NUM_REQ-1:0]            RESP_VALID;
    logic [DATA_WIDTH-1:0]         RESP_DATA;
    logic [NUM_REQ-1:0]            RESP_READY;
    logic                          MEM_SEND_ADDR_VALID;
    logic [ADDR_WIDTH-1:0]         MEM_SEND_ADDR;
    logic                          MEM_SEND_DATA_VALID;
    logic [DATA_WIDTH-1:0]         MEM_SEND_DATA;
    logic                          MEM_SEND_READY;
    logic                          MEM_RECEIVE_VALID;
    logic [DATA_WIDTH-1:0]         MEM_RECEIVE_DATA;
    logic                          MEM_RECEIVE_READY;
    logic [IDX_W-1:0]              GRANT_IDX;
    logic                          BUSY;

    modport slave (
        input  REQ_ADDR_VALID, REQ_ADDR, REQ_DATA_VALID, REQ_DATA, RESP_READY,
        input  MEM_SEND_READY, MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
        output REQ_READY, RESP_VALID, RESP_DATA,
        output MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA,
        output MEM_RECEIVE_READY, GRANT_IDX, BUSY
    );

    modport master (
        output REQ_ADDR_VALID, REQ_ADDR, REQ_DATA_VALID, REQ_DATA, RESP_READY,
        output MEM_SEND_READY, MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
        input  REQ_READY, RESP_VALID, RESP_DATA,
        input  MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA,
        input  MEM_RECEIVE_READY, GRANT_IDX, BUSY
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port among NUM_REQ requesters
// One transaction in flight: grant, issue to memory, wait for response, return to the winner.
module mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RETURN = 2'd3;

    logic [1:0]            state;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  found;
    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      cand;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_wr;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan farthest-to-nearest from ptr so the nearest valid requester wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (bus.REQ_ADDR_VALID[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_addr = bus.REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wr   = bus.REQ_DATA_VALID[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            ptr       <= IDX_W'(NUM_REQ - 1);
            grant_idx <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_idx <= winner;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_data;
                        wr_q      <= sel_wr;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.MEM_SEND_READY) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.MEM_RECEIVE_VALID) begin
                        rdata_q <= bus.MEM_RECEIVE_DATA;
                        state   <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    // Only the granted requester's accept releases the port.
                    if (bus.RESP_READY[grant_idx]) begin
                        ptr   <= grant_idx;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Grant is combinational, so it must be masked while reset is held.
    assign bus.REQ_READY           = (state == S_IDLE && found && !RST) ? onehot(winner) : '0;
    assign bus.RESP_VALID          = (state == S_RETURN) ? onehot(grant_idx) : '0;
    assign bus.RESP_DATA           = rdata_q;
    assign bus.MEM_SEND_ADDR_VALID = (state == S_ISSUE);
    assign bus.MEM_SEND_DATA_VALID = (state == S_ISSUE) && wr_q;
    assign bus.MEM_SEND_ADDR       = addr_q;
    assign bus.MEM_SEND_DATA       = wdata_q;
    assign bus.MEM_RECEIVE_READY   = (state == S_WAIT);
    assign bus.GRANT_IDX           = grant_idx;
    assign bus.BUSY                = (state != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // requester / memory stimulus
    bit            rv [N];
    logic [AW-1:0] ra [N];
    logic [DW-1:0] rd [N];
    bit            rw [N];
    bit            s_ready, r_valid, rst_q, rand_mode, hold_all;
    logic [DW-1:0] r_data;
    logic [N-1:0]  p_ready;

    // transaction-level reference
    int            owner, last_g, grant_m;
    bit            sent, got, wr_m;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] wdata_m, resp_m;
    int            pend [N];

    int cyc;
    bit prev_sav;
    int glog[$];
    int gcyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        last_g  = N - 1;
        grant_m = 0;
        sent    = 1'b0;
        got     = 1'b0;
        wr_m    = 1'b0;
        addr_m  = '0;
        wdata_m = '0;
        resp_m  = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
    endtask

    task automatic cycle();
        logic [N*AW-1:0] fa;
        logic [N*DW-1:0] fd;
        logic [N-1:0]    fv, fw, exp_rr, exp_rv;
        int              w;
        @(negedge clk);
        cyc++;
        if (rand_mode) begin
            s_ready = ($urandom_range(0, 2) != 0);
            r_valid = ($urandom_range(0, 2) == 0);
            r_data  = $urandom;
            p_ready = N'($urandom);
            rst_q   = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i]   = 1'b1;
                    ra[i]   = $urandom;
                    rd[i]   = $urandom;
                    rw[i]   = 1'($urandom_range(0, 1));
                    pend[i] = 0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            fv[i]            = rv[i];
            fw[i]            = rw[i];
            fa[i*AW +: AW]   = ra[i];
            fd[i*DW +: DW]   = rd[i];
        end
        rst                   = rst_q;
        bus.REQ_ADDR_VALID    = fv;
        bus.REQ_ADDR          = fa;
        bus.REQ_DATA_VALID    = fw;
        bus.REQ_DATA          = fd;
        bus.RESP_READY        = p_ready;
        bus.MEM_SEND_READY    = s_ready;
        bus.MEM_RECEIVE_VALID = r_valid;
        bus.MEM_RECEIVE_DATA  = r_data;
        #1;
        w = -1;
        if (!rst_q && owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (last_g + k) % N;
                if (rv[j] && w < 0) w = j;
            end
        end
        exp_rr = (w >= 0) ? (N'(1) << w) : '0;
        exp_rv = (owner >= 0 && got) ? (N'(1) << owner) : '0;
        chk("req_ready",  64'(bus.REQ_READY),           64'(exp_rr));
        chk("resp_valid", 64'(bus.RESP_VALID),          64'(exp_rv));
        chk("resp_data",  64'(bus.RESP_DATA),           64'(resp_m));
        chk("send_valid", 64'(bus.MEM_SEND_ADDR_VALID), 64'(owner >= 0 && !sent));
        chk("send_wr",    64'(bus.MEM_SEND_DATA_VALID), 64'(owner >= 0 && !sent && wr_m));
        chk("send_addr",  64'(bus.MEM_SEND_ADDR),       64'(addr_m));
        chk("send_data",  64'(bus.MEM_SEND_DATA),       64'(wdata_m));
        chk("recv_ready", 64'(bus.MEM_RECEIVE_READY),   64'(owner >= 0 && sent && !got));
        chk("grant_idx",  64'(bus.GRANT_IDX),           64'(grant_m));
        chk("busy",       64'(bus.BUSY),                64'(owner >= 0));
        if (bus.MEM_SEND_ADDR_VALID === 1'b1 && !prev_sav) begin
            glog.push_back(int'(bus.GRANT_IDX));
            gcyc.push_back(cyc);
        end
        prev_sav = (bus.MEM_SEND_ADDR_VALID === 1'b1);

        if (rst_q) begin
            model_reset();
        end else if (owner < 0) begin
            if (w >= 0) begin
                chk("fairness", 64'(pend[w] <= N - 1), 64'(1));
                pend[w] = 0;
                for (int i = 0; i < N; i++) if (i != w && rv[i]) pend[i]++;
                owner   = w;
                grant_m = w;
                addr_m  = ra[w];
                wdata_m = rd[w];
                wr_m    = rw[w];
                if (!hold_all) rv[w] = 1'b0;
            end
        end else if (!sent) begin
            if (s_ready) sent = 1'b1;
        end else if (!got) begin
            if (r_valid) begin
                got    = 1'b1;
                resp_m = r_data;
            end
        end else if (p_ready[owner]) begin
            last_g = owner;
            owner  = -1;
            sent   = 1'b0;
            got    = 1'b0;
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        s_ready  = 1'b1;
        r_valid  = 1'b0;
        r_data   = '0;
        p_ready  = '1;
        rst_q    = 1'b0;
        hold_all = 1'b0;
    endtask

    task automatic do_reset();
        rst_q = 1'b1;
        cycle();
        cycle();
        rst_q = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.REQ_ADDR_VALID = '0; bus.REQ_ADDR = '0; bus.REQ_DATA_VALID = '0; bus.REQ_DATA = '0;
        bus.RESP_READY = '0; bus.MEM_SEND_READY = 1'b0; bus.MEM_RECEIVE_VALID = 1'b0;
        bus.MEM_RECEIVE_DATA = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; rw[i] = 1'b0; end
        clear_stim();
        model_reset();
        rand_mode = 1'b0;
        cyc = 0;
        prev_sav = 1'b0;
        repeat (2) @(posedge clk);

        // reset held with every requester valid
        for (int i = 0; i < N; i++) rv[i] = 1'b1;
        rst_q = 1'b1;
        cycle();
        chk("t1_req_ready",  64'(bus.REQ_READY),           64'(0));
        chk("t1_send_valid", 64'(bus.MEM_SEND_ADDR_VALID), 64'(0));
        chk("t1_resp_valid", 64'(bus.RESP_VALID),          64'(0));
        chk("t1_busy",       64'(bus.BUSY),                64'(0));
        cycle();
        clear_stim();

        // single read from requester 1
        do_reset();
        rv[1] = 1'b1; ra[1] = 32'h1234; rd[1] = '0; rw[1] = 1'b0;
        n = 0;
        while (bus.MEM_SEND_ADDR_VALID !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("t2_send_seen", 64'(n < 20), 64'(1));
        chk("t2_addr", 64'(bus.MEM_SEND_ADDR), 64'h1234);
        chk("t2_wr",   64'(bus.MEM_SEND_DATA_VALID), 64'(0));
        r_valid = 1'b1; r_data = 32'hDEADBEEF;
        n = 0;
        while (bus.RESP_VALID === 4'b0000 && n < 20) begin cycle(); n++; end
        chk("t2_resp_valid", 64'(bus.RESP_VALID), 64'(4'b0010));
        chk("t2_resp_data",  64'(bus.RESP_DATA),  64'hDEADBEEF);
        clear_stim();

        // single write from requester 2 with a send stall
        do_reset();
        s_ready = 1'b0;
        rv[2] = 1'b1; ra[2] = 32'h10; rd[2] = 32'hA5A5A5A5; rw[2] = 1'b1;
        n = 0;
        while (bus.MEM_SEND_ADDR_VALID !== 1'b1 && n < 20) begin cycle(); n++; end
        for (int k = 0; k < 3; k++) begin
            chk("t3_addr", 64'(bus.MEM_SEND_ADDR),       64'h10);
            chk("t3_data", 64'(bus.MEM_SEND_DATA),       64'hA5A5A5A5);
            chk("t3_wr",   64'(bus.MEM_SEND_DATA_VALID), 64'(1));
            cycle();
        end
        chk("t3_still_valid", 64'(bus.MEM_SEND_ADDR_VALID), 64'(1));
        s_ready = 1'b1; r_valid = 1'b1; r_data = 32'h77;
        n = 0;
        while (bus.RESP_VALID === 4'b0000 && n < 20) begin cycle(); n++; end
        chk("t3_resp_valid", 64'(bus.RESP_VALID), 64'(4'b0100));
        chk("t3_resp_data",  64'(bus.RESP_DATA),  64'h77);
        clear_stim();

        // round robin with all requesters held valid
        do_reset();
        for (int i = 0; i < N; i++) begin rv[i] = 1'b1; ra[i] = AW'(i * 32'h100); rd[i] = DW'(i); rw[i] = 1'b0; end
        hold_all = 1'b1; r_valid = 1'b1; r_data = 32'h55;
        glog.delete(); gcyc.delete();
        n = 0;
        while (glog.size() < 8 && n < 100) begin cycle(); n++; end
        chk("t4_count", 64'(glog.size()), 64'(8));
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("t4_order", 64'(glog[k]), 64'(k % 4));
        for (int k = 1; k < 8 && k < gcyc.size(); k++) chk("t4_interval", 64'(gcyc[k] - gcyc[k-1]), 64'(4));
        clear_stim();

        // response backpressure with a competing requester
        do_reset();
        rv[0] = 1'b1; ra[0] = 32'hA0; rv[1] = 1'b1; ra[1] = 32'hB0;
        p_ready = '0; r_valid = 1'b1; r_data = 32'h99;
        n = 0;
        while (bus.RESP_VALID === 4'b0000 && n < 20) begin cycle(); n++; end
        chk("t5_resp_valid", 64'(bus.RESP_VALID), 64'(4'b0001));
        p_ready = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t5_held",       64'(bus.RESP_VALID),          64'(4'b0001));
            chk("t5_no_send",    64'(bus.MEM_SEND_ADDR_VALID), 64'(0));
            chk("t5_no_grant",   64'(bus.REQ_READY),           64'(0));
        end
        p_ready = '1;
        n = 0;
        while (bus.MEM_SEND_ADDR_VALID !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("t5_next_grant", 64'(bus.GRANT_IDX), 64'(1));
        clear_stim();

        // reset while waiting for memory
        do_reset();
        rv[2] = 1'b1; ra[2] = 32'hC0;
        n = 0;
        while (bus.MEM_RECEIVE_READY !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("t6_in_wait", 64'(bus.MEM_RECEIVE_READY), 64'(1));
        rst_q = 1'b1;
        cycle();
        rst_q = 1'b0;
        rv[0] = 1'b1; ra[0] = 32'hD0; rv[2] = 1'b1; r_valid = 1'b1;
        cycle();
        chk("t6_busy",       64'(bus.BUSY),       64'(0));
        chk("t6_resp_valid", 64'(bus.RESP_VALID), 64'(0));
        chk("t6_req_ready",  64'(bus.REQ_READY),  64'(4'b0001));
        cycle();
        chk("t6_grant",      64'(bus.GRANT_IDX),  64'(0));
        clear_stim();

        // randomized traffic against the reference
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) cycle();
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
